// File: rtl/sigma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sigma_bus_arbiter
// Brief   : Two-master / one-slave bus arbiter with grant lock and an in-order
//           read tag FIFO that steers slave responses back to the issuer.
// Rev     : 1.0  initial release
// ============================================================================
module sigma_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int PRIO_MODE  = 0,
  parameter int RESP_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                arst_i,

  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_ack_o,
  output logic                m0_resp_o,
  output logic [DATA_W-1:0]   m0_rdata_o,

  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_ack_o,
  output logic                m1_resp_o,
  output logic [DATA_W-1:0]   m1_rdata_o,

  output logic                s_req_o,
  output logic                s_we_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W/8-1:0] s_be_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  input  logic                s_ack_i,
  input  logic                s_resp_i,
  input  logic [DATA_W-1:0]   s_rdata_i,

  output logic                err_o
);

  localparam int                 c_ptr_w   = $clog2(RESP_DEPTH);
  localparam int                 c_cnt_w   = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(RESP_DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  typedef enum logic [0:0] {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e           state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  last_q, last_d;
  logic [RESP_DEPTH-1:0] tag_q, tag_d;
  logic [c_ptr_w-1:0]    wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0]    rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0]    count_q, count_d;
  logic                  err_q, err_d;

  logic full;
  logic can0;
  logic can1;
  logic gnt;
  logic sel_we;
  logic s_req;
  logic accept;
  logic push;
  logic pop;
  logic head;

  // A read may only compete while the tag FIFO has room; writes always can.
  always_comb begin
    full = (count_q == c_full);
    can0 = m0_req_i & ~(full & ~m0_we_i);
    can1 = m1_req_i & ~(full & ~m1_we_i);

    if (state_q == ST_LOCKED) begin
      gnt = gnt_q;
    end else if (PRIO_MODE != 0) begin
      gnt = ~m0_req_i;
    end else if (last_q) begin
      gnt = ~can0 & can1;
    end else begin
      gnt = can1 | ~can0;
    end

    sel_we = gnt ? m1_we_i : m0_we_i;
    s_req  = (gnt ? can1 : can0) & ~arst_i;
    accept = s_req & s_ack_i;
    push   = accept & ~sel_we;
    head   = tag_q[rd_ptr_q];
    pop    = s_resp_i & (count_q != '0) & ~arst_i;
  end

  assign s_req_o    = s_req;
  assign s_we_o     = sel_we;
  assign s_addr_o   = gnt ? m1_addr_i  : m0_addr_i;
  assign s_be_o     = gnt ? m1_be_i    : m0_be_i;
  assign s_wdata_o  = gnt ? m1_wdata_i : m0_wdata_i;

  assign m0_ack_o   = accept & ~gnt;
  assign m1_ack_o   = accept &  gnt;
  assign m0_resp_o  = pop & ~head;
  assign m1_resp_o  = pop &  head;
  assign m0_rdata_o = s_rdata_i;
  assign m1_rdata_o = s_rdata_i;
  assign err_o      = err_q;

  always_comb begin
    state_d  = ST_OPEN;
    gnt_d    = gnt_q;
    last_d   = last_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;

    if (s_req & ~s_ack_i) begin
      state_d = ST_LOCKED;
      gnt_d   = gnt;
    end

    if (accept) begin
      last_d = gnt;
    end

    if (push) begin
      tag_d[wr_ptr_q] = gnt;
      wr_ptr_d        = wr_ptr_q + c_ptr_one;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + c_ptr_one;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase

    // A response with nothing outstanding is dropped and flagged.
    if (s_resp_i & (count_q == '0)) begin
      err_d = 1'b1;
    end
  end

  // last_q resets to m1 so that m0 holds round-robin priority first.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= ST_OPEN;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sigma_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_sigma_bus_arbiter
// Brief   : Scoreboard bench for sigma_bus_arbiter with a queue-based model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sigma_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int DEPTH  = 4;
  localparam int PRIO   = 0;

  logic              clk = 1'b0;
  logic              arst_i = 1'b0;
  logic              m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [ADDR_W-1:0] m0_addr_i, m1_addr_i, s_addr_o;
  logic [BE_W-1:0]   m0_be_i, m1_be_i, s_be_o;
  logic [DATA_W-1:0] m0_wdata_i, m1_wdata_i, s_wdata_o;
  logic              m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
  logic [DATA_W-1:0] m0_rdata_o, m1_rdata_o, s_rdata_i;
  logic              s_req_o, s_we_o, s_ack_i, s_resp_i, err_o;

  sigma_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRIO_MODE(PRIO), .RESP_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .arst_i(arst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_ack_o(m0_ack_o),
    .m0_resp_o(m0_resp_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_ack_o(m1_ack_o),
    .m1_resp_o(m1_resp_o), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_be_o(s_be_o),
    .s_wdata_o(s_wdata_o), .s_ack_i(s_ack_i), .s_resp_i(s_resp_i),
    .s_rdata_i(s_rdata_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              cyc;
    int              id;
    logic            we;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0] be;
    logic [DATA_W-1:0] wd;
  } acc_t;

  typedef struct {
    int              cyc;
    int              id;
    logic [DATA_W-1:0] data;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];
  int   err_q[$];

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: who won last, who is locked (-1 none), outstanding read owners.
  int mdl_last = 1;
  int mdl_lock = -1;
  int mdl_tags[$];
  bit mdl_err  = 1'b0;

  // Master-side pending requests (held until accepted).
  bit                p_req [2];
  logic              p_we  [2];
  logic [ADDR_W-1:0] p_addr[2];
  logic [BE_W-1:0]   p_be  [2];
  logic [DATA_W-1:0] p_wd  [2];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void unexpected(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: got an event expected none (cycle %0d)", name, cyc);
  endfunction

  function automatic void mdl_reset();
    mdl_last = 1;
    mdl_lock = -1;
    mdl_tags.delete();
    mdl_err  = 1'b0;
    for (int m = 0; m < 2; m++) p_req[m] = 1'b0;
  endfunction

  function automatic void issue(input int m, input logic we, input logic [ADDR_W-1:0] a);
    if (!p_req[m]) begin
      p_req[m]  = 1'b1;
      p_we[m]   = we;
      p_addr[m] = a;
      p_be[m]   = BE_W'($urandom);
      p_wd[m]   = $urandom;
    end
  endfunction

  // One cycle of the arbiter, derived from the rules: pick the winner, route
  // responses from the oldest outstanding read, then record the new read.
  function automatic void model_cycle(input bit sack, input bit sresp, input logic [DATA_W-1:0] rd);
    int win;
    int pri;
    int h;
    bit full;
    bit can [2];
    full = (mdl_tags.size() == DEPTH);
    for (int m = 0; m < 2; m++) can[m] = p_req[m] && !(full && !p_we[m]);
    if (mdl_lock >= 0) begin
      win = mdl_lock;
    end else if (PRIO != 0) begin
      win = p_req[0] ? (can[0] ? 0 : -1) : (can[1] ? 1 : -1);
    end else begin
      pri = 1 - mdl_last;
      win = can[pri] ? pri : (can[1-pri] ? 1 - pri : -1);
    end
    if (sresp) begin
      if (mdl_tags.size() > 0) begin
        h = mdl_tags.pop_front();
        rsp_q.push_back('{cyc, h, rd});
      end else if (!mdl_err) begin
        mdl_err = 1'b1;
        err_q.push_back(cyc + 1);
      end
    end
    if (win >= 0 && sack) begin
      acc_q.push_back('{cyc, win, p_we[win], p_addr[win], p_be[win], p_wd[win]});
      mdl_last = win;
      if (!p_we[win]) mdl_tags.push_back(win);
      p_req[win] = 1'b0;
      mdl_lock   = -1;
    end else begin
      mdl_lock = win;
    end
  endfunction

  task automatic drive_idle();
    m0_req_i = 1'b0; m0_we_i = 1'b0; m0_addr_i = '0; m0_be_i = '0; m0_wdata_i = '0;
    m1_req_i = 1'b0; m1_we_i = 1'b0; m1_addr_i = '0; m1_be_i = '0; m1_wdata_i = '0;
    s_ack_i  = 1'b0; s_resp_i = 1'b0; s_rdata_i = '0;
  endtask

  // Drives one cycle shortly after the edge; returns 3 ns later for direct checks.
  task automatic step(input bit sack, input bit sresp, input logic [DATA_W-1:0] rd);
    @(posedge clk);
    #1;
    m0_req_i = p_req[0]; m0_we_i = p_we[0]; m0_addr_i = p_addr[0];
    m0_be_i  = p_be[0];  m0_wdata_i = p_wd[0];
    m1_req_i = p_req[1]; m1_we_i = p_we[1]; m1_addr_i = p_addr[1];
    m1_be_i  = p_be[1];  m1_wdata_i = p_wd[1];
    s_ack_i  = sack; s_resp_i = sresp; s_rdata_i = rd;
    model_cycle(sack, sresp, rd);
    #2;
  endtask

  task automatic settle();
    int guard = 0;
    while ((p_req[0] || p_req[1]) && guard < 50) begin
      step(1'b1, mdl_tags.size() > 0, $urandom);
      guard++;
    end
    while (mdl_tags.size() > 0 && guard < 100) begin
      step(1'b0, 1'b1, $urandom);
      guard++;
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_s_req"},  s_req_o,   1'b0);
    chk({tag, "_m0_ack"}, m0_ack_o,  1'b0);
    chk({tag, "_m1_ack"}, m1_ack_o,  1'b0);
    chk({tag, "_m0_rsp"}, m0_resp_o, 1'b0);
    chk({tag, "_m1_rsp"}, m1_resp_o, 1'b0);
    chk({tag, "_err"},    err_o,     1'b0);
  endtask

  // Monitor: pops expectations only when the DUT shows an acceptance,
  // a routed response or a rising error flag.
  acc_t mon_a;
  rsp_t mon_r;
  logic err_prev = 1'b0;

  always @(negedge clk) begin
    if (!arst_i) begin
      if ((s_req_o && s_ack_i) || m0_ack_o || m1_ack_o) begin
        if (acc_q.size() == 0) begin
          unexpected("accept");
        end else begin
          mon_a = acc_q.pop_front();
          chk("accept_cycle", 64'(cyc), 64'(mon_a.cyc));
          chk("accept_ids", {m1_ack_o, m0_ack_o}, (mon_a.id == 0) ? 2'b01 : 2'b10);
          chk("accept_handshake", s_req_o & s_ack_i, 1'b1);
          chk("accept_we", s_we_o, mon_a.we);
          chk("accept_addr", s_addr_o, mon_a.addr);
          chk("accept_be", s_be_o, mon_a.be);
          if (mon_a.we) chk("accept_wdata", s_wdata_o, mon_a.wd);
        end
      end
      if (m0_resp_o || m1_resp_o) begin
        if (rsp_q.size() == 0) begin
          unexpected("response");
        end else begin
          mon_r = rsp_q.pop_front();
          chk("resp_cycle", 64'(cyc), 64'(mon_r.cyc));
          chk("resp_target", {m1_resp_o, m0_resp_o}, (mon_r.id == 0) ? 2'b01 : 2'b10);
          chk("resp_rdata", (mon_r.id == 0) ? m0_rdata_o : m1_rdata_o, mon_r.data);
        end
      end
      if (err_o && !err_prev) begin
        if (err_q.size() == 0) unexpected("err_rise");
        else chk("err_rise_cycle", 64'(cyc), 64'(err_q.pop_front()));
      end
    end
    err_prev = err_o;
  end

  initial begin
    drive_idle();
    mdl_reset();
    #1 arst_i = 1'b1;
    #1 chk_outputs_zero("por");
    repeat (2) @(posedge clk);
    #1 arst_i = 1'b0;

    // Both masters read continuously: strict alternation starting with m0.
    for (int i = 0; i < 6; i++) begin
      issue(0, 1'b0, 32'h0000_1000 + 32'(i * 4));
      issue(1, 1'b0, 32'h0000_1800 + 32'(i * 4));
      step(1'b1, mdl_tags.size() > 0, $urandom);
      chk("rr_alternate", {m1_ack_o, m0_ack_o}, (i % 2 == 1) ? 2'b10 : 2'b01);
    end
    settle();

    // Make m1 the last winner so m0 would have priority, then lock on m1.
    issue(1, 1'b1, 32'h0000_0040);
    step(1'b1, 1'b0, '0);
    issue(1, 1'b0, 32'h0000_2000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0);
      chk("lock_s_req", s_req_o, 1'b1);
      chk("lock_addr", s_addr_o, 32'h0000_2000);
    end
    issue(0, 1'b0, 32'h0000_3000);
    step(1'b0, 1'b0, '0);
    chk("lock_hold_addr", s_addr_o, 32'h0000_2000);
    step(1'b1, 1'b0, '0);
    chk("lock_release_m1", {m1_ack_o, m0_ack_o}, 2'b10);
    step(1'b1, 1'b0, '0);
    chk("after_lock_m0", {m1_ack_o, m0_ack_o}, 2'b01);
    settle();

    // Fill the tag FIFO, then a 5th read waits for a response.
    for (int r = 0; r < 2; r++) begin
      issue(0, 1'b0, 32'h0000_4000 + 32'(r * 16));
      issue(1, 1'b0, 32'h0000_4800 + 32'(r * 16));
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b0, '0);
    end
    issue(0, 1'b0, 32'h0000_5000);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, '0);
      chk("full_block_ack", m0_ack_o, 1'b0);
      chk("full_block_req", s_req_o, 1'b0);
    end
    step(1'b1, 1'b1, 32'hC0DE_0001);
    chk("full_block_same_cycle_pop", m0_ack_o, 1'b0);
    step(1'b1, 1'b0, '0);
    chk("accept_after_pop", m0_ack_o, 1'b1);
    settle();

    // Interleaved reads return to their issuers in order.
    issue(0, 1'b0, 32'h0000_0100);
    step(1'b1, 1'b0, '0);
    issue(1, 1'b0, 32'h0000_0200);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 32'h0000_AAAA);
    chk("route_m0_resp", {m1_resp_o, m0_resp_o}, 2'b01);
    chk("route_m0_data", m0_rdata_o, 32'h0000_AAAA);
    step(1'b0, 1'b1, 32'h0000_BBBB);
    chk("route_m1_resp", {m1_resp_o, m0_resp_o}, 2'b10);
    chk("route_m1_data", m1_rdata_o, 32'h0000_BBBB);

    // Stray response sets the sticky error flag.
    chk("err_before_stray", err_o, 1'b0);
    step(1'b0, 1'b1, 32'h0000_1234);
    chk("stray_no_resp", {m1_resp_o, m0_resp_o}, 2'b00);
    step(1'b0, 1'b0, '0);
    chk("err_set", err_o, 1'b1);
    repeat (3) step(1'b0, 1'b0, '0);
    chk("err_sticky", err_o, 1'b1);

    // Asynchronous reset with two reads outstanding.
    issue(0, 1'b0, 32'h0000_6000);
    step(1'b1, 1'b0, '0);
    issue(1, 1'b0, 32'h0000_7000);
    step(1'b1, 1'b0, '0);
    @(posedge clk);
    #1;
    arst_i = 1'b1;
    mdl_reset();
    m0_req_i = 1'b1; m0_we_i = 1'b0; s_ack_i = 1'b1; s_resp_i = 1'b1;
    #1 chk_outputs_zero("mid_reset");
    @(posedge clk);
    #1 drive_idle();
    @(posedge clk);
    #1 arst_i = 1'b0;
    step(1'b0, 1'b1, 32'h0000_5555);
    chk("post_reset_stray_no_resp", {m1_resp_o, m0_resp_o}, 2'b00);
    step(1'b0, 1'b0, '0);
    chk("post_reset_err", err_o, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!p_req[m] && $urandom_range(0, 2) == 0) begin
          issue(m, $urandom_range(0, 1) == 1, $urandom);
        end
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom);
    end
    settle();

    @(posedge clk);
    #6;
    chk("acc_q_drained", 64'(acc_q.size()), 64'd0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    chk("err_q_drained", 64'(err_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
